pmul_acc: RTL and testbench

Parametrised successor to the fixed 3-tap partial multiplier. It computes a signed TAPS-wide dot product of a data row against a weight row per beat. It optionally accumulates several beats into one partial sum, then rescales and saturates the result to PSUM_W. Weights are double-buffered: a serial shadow load runs while the active set keeps serving data. The block sits between the line-buffer window output and the output-channel adder in the convolution datapath.

---
 rtl/pmul_pkg.sv | 36 +++
 rtl/pmul_sat.sv | 35 +++
 rtl/pmul_acc.sv | 109 ++++++++++
 tb/tb_pmul_acc.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/pmul_pkg.sv
// Shared helpers for the partial-multiply datapath: width derivation and
// the shift/saturate step also used by the output-channel adder.
package pmul_pkg;

  localparam int SAT_MAX_W = 64;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

  function automatic int acc_w(input int data_w, input int wgt_w, input int taps,
                               input int guard);
    return data_w + wgt_w + clog2(taps) + guard;
  endfunction

  // Arithmetic shift (floor), then clamp to psum_w when sat is set; callers
  // keep the low psum_w bits, which gives wrap behaviour when sat is clear.
  function automatic logic signed [SAT_MAX_W-1:0] sat_trunc(
    input logic signed [SAT_MAX_W-1:0] v,
    input int                          shift,
    input int                          psum_w,
    input logic                        sat
  );
    logic signed [SAT_MAX_W-1:0] r, hi, lo;
    r  = v >>> shift;
    hi = (SAT_MAX_W'(1) << (psum_w - 1)) - SAT_MAX_W'(1);
    lo = ~hi;
    if (sat && (r > hi))      r = hi;
    else if (sat && (r < lo)) r = lo;
    return r;
  endfunction

endpackage

// File: rtl/pmul_sat.sv
// Output stage: rescale the finished group sum and register psum/psum_vld.
module pmul_sat
  import pmul_pkg::*;
#(
  parameter int ACC_W  = 22,
  parameter int PSUM_W = 8,
  parameter int SHIFT  = 0,
  parameter int SAT    = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_vld,
  input  logic [ACC_W-1:0]  acc,
  output logic [PSUM_W-1:0] psum,
  output logic              psum_vld
);

  logic signed [SAT_MAX_W-1:0] acc_ext, res;
  logic                        unused_res;

  assign acc_ext    = SAT_MAX_W'($signed(acc));
  assign res        = sat_trunc(acc_ext, SHIFT, PSUM_W, SAT != 0);
  assign unused_res = ^res[SAT_MAX_W-1:PSUM_W];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      psum     <= '0;
      psum_vld <= 1'b0;
    end else begin
      psum_vld <= in_vld;
      if (in_vld) psum <= res[PSUM_W-1:0];
    end
  end

endmodule

// File: rtl/pmul_acc.sv
// Signed TAPS-wide dot product with multi-beat accumulation, double-buffered
// weights and a scaled/saturated output; three register stages deep.
module pmul_acc
  import pmul_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int WGT_W     = 8,
  parameter int TAPS      = 3,
  parameter int PSUM_W    = 8,
  parameter int SHIFT     = 0,
  parameter int SAT       = 1,
  parameter int ACC_GUARD = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [TAPS*DATA_W-1:0] in_data,
  input  logic                   in_vld,
  input  logic                   in_first,
  input  logic                   in_last,
  input  logic [WGT_W-1:0]       in_weight,
  input  logic                   in_wgt_vld,
  input  logic                   in_update,
  output logic [PSUM_W-1:0]      psum,
  output logic                   psum_vld
);

  localparam int PROD_W = DATA_W + WGT_W;
  localparam int ACC_W  = acc_w(DATA_W, WGT_W, TAPS, ACC_GUARD);

  logic [TAPS-1:0][WGT_W-1:0]  shadow, active;
  logic [TAPS-1:0][PROD_W-1:0] prod_c, prod_q;
  logic [2:1]                  vld_pipe;
  logic                        first_q, last_q, grp_done;
  logic [ACC_W-1:0]            sum_chain [TAPS+1];
  logic [ACC_W-1:0]            acc_q, acc_base, acc_nxt;

  // NBA semantics give in_update the pre-shift shadow for free.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shadow <= '0;
      active <= '0;
    end else begin
      if (in_wgt_vld) begin
        shadow[0] <= in_weight;
        for (int i = 1; i < TAPS; i++) shadow[i] <= shadow[i-1];
      end
      if (in_update) active <= shadow;
    end
  end

  for (genvar i = 0; i < TAPS; i++) begin : g_mul
    logic signed [DATA_W-1:0] d;
    logic signed [WGT_W-1:0]  w;
    logic signed [PROD_W-1:0] p;
    assign d         = in_data[i*DATA_W +: DATA_W];
    assign w         = active[i];
    assign p         = d * w;
    assign prod_c[i] = p;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_pipe <= '0;
      first_q  <= 1'b0;
      last_q   <= 1'b0;
      prod_q   <= '0;
    end else begin
      vld_pipe <= {vld_pipe[1], in_vld};
      first_q  <= in_first;
      last_q   <= in_last;
      if (in_vld) prod_q <= prod_c;
    end
  end

  assign sum_chain[0] = '0;
  for (genvar i = 0; i < TAPS; i++) begin : g_sum
    assign sum_chain[i+1] = sum_chain[i] + ACC_W'($signed(prod_q[i]));
  end

  // acc_q keeps the finished group total for the output stage; grp_done makes
  // the next beat start from zero, which is the post-last clear.
  assign acc_base = (first_q || grp_done) ? '0 : acc_q;
  assign acc_nxt  = acc_base + sum_chain[TAPS];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc_q    <= '0;
      grp_done <= 1'b0;
    end else if (vld_pipe[1]) begin
      acc_q    <= acc_nxt;
      grp_done <= last_q;
    end
  end

  pmul_sat #(
    .ACC_W (ACC_W),
    .PSUM_W(PSUM_W),
    .SHIFT (SHIFT),
    .SAT   (SAT)
  ) u_sat (
    .clk     (clk),
    .rst     (rst),
    .in_vld  (vld_pipe[2] & grp_done),
    .acc     (acc_q),
    .psum    (psum),
    .psum_vld(psum_vld)
  );

endmodule

// File: tb/tb_pmul_acc.sv
// Bench for pmul_acc: three parameter variants driven in parallel, checked
// every cycle against a beat-level arithmetic model plus literal results.
module tb_pmul_acc;

  localparam int ND = 3;
  localparam int SH [ND] = '{0, 2, 0};
  localparam int SA [ND] = '{1, 1, 0};

  logic        clk, rst;
  logic [23:0] in_data;
  logic        in_vld, in_first, in_last, in_wgt_vld, in_update;
  logic [7:0]  in_weight;
  logic [7:0]  ps [ND];
  logic        pv [ND];

  int checks = 0;
  int errors = 0;
  bit chk_en = 0;

  pmul_acc u0 (
    .clk(clk), .rst(rst), .in_data(in_data), .in_vld(in_vld), .in_first(in_first),
    .in_last(in_last), .in_weight(in_weight), .in_wgt_vld(in_wgt_vld),
    .in_update(in_update), .psum(ps[0]), .psum_vld(pv[0]));
  pmul_acc #(.SHIFT(2)) u1 (
    .clk(clk), .rst(rst), .in_data(in_data), .in_vld(in_vld), .in_first(in_first),
    .in_last(in_last), .in_weight(in_weight), .in_wgt_vld(in_wgt_vld),
    .in_update(in_update), .psum(ps[1]), .psum_vld(pv[1]));
  pmul_acc #(.SAT(0)) u2 (
    .clk(clk), .rst(rst), .in_data(in_data), .in_vld(in_vld), .in_first(in_first),
    .in_last(in_last), .in_weight(in_weight), .in_wgt_vld(in_wgt_vld),
    .in_update(in_update), .psum(ps[2]), .psum_vld(pv[2]));

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  // Reference model: whole beats, integer dot products, a queue of results.
  typedef struct { longint due; longint val; } ev_t;
  typedef logic [ND-1:0][7:0] trip_t;

  ev_t    q[$];
  trip_t  got[$];
  int     act [3];
  int     shd [3];
  longint acc  = 0;
  bit     done = 0;
  longint cyc  = 0;
  logic [7:0] exp_ps [ND];

  function automatic int scale(input longint v, input int k);
    longint r;
    r = v >>> SH[k];
    if (SA[k] != 0) begin
      if (r > 127)  r = 127;
      if (r < -128) r = -128;
    end
    return int'(r & 255);
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 3; i++) begin act[i] = 0; shd[i] = 0; end
      acc = 0; done = 0; q.delete();
      for (int k = 0; k < ND; k++) exp_ps[k] = 8'h00;
    end else begin
      cyc++;
      if (in_vld) begin
        longint dot;
        logic [7:0] d;
        dot = 0;
        for (int i = 0; i < 3; i++) begin
          d = in_data[i*8 +: 8];
          dot += longint'($signed(d)) * act[i];
        end
        acc  = ((in_first || done) ? 0 : acc) + dot;
        done = in_last;
        if (in_last) q.push_back('{cyc + 2, acc});
      end
      if (in_update) act = shd;
      if (in_wgt_vld) begin
        shd[2] = shd[1]; shd[1] = shd[0]; shd[0] = int'($signed(in_weight));
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      bit ev;
      ev = (q.size() > 0) && (q[0].due == cyc);
      if (ev) begin
        for (int k = 0; k < ND; k++) exp_ps[k] = 8'(scale(q[0].val, k));
        void'(q.pop_front());
      end
      for (int k = 0; k < ND; k++) begin
        checks++;
        if (pv[k] !== ev) begin
          errors++;
          $display("FAIL psum_vld dut%0d cyc %0d got %b want %b", k, cyc, pv[k], ev);
        end
        checks++;
        if (ps[k] !== exp_ps[k]) begin
          errors++;
          $display("FAIL psum dut%0d cyc %0d got %h want %h", k, cyc, ps[k], exp_ps[k]);
        end
      end
      if (pv[0] === 1'b1) got.push_back({ps[2], ps[1], ps[0]});
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    in_vld = 0; in_first = 0; in_last = 0; in_wgt_vld = 0; in_update = 0;
  endtask

  task automatic load_w(input logic [7:0] w);
    in_weight = w; in_wgt_vld = 1;
    tick();
    in_wgt_vld = 0;
  endtask

  task automatic upd();
    in_update = 1;
    tick();
    in_update = 0;
  endtask

  task automatic beat(input logic [7:0] t2, input logic [7:0] t1, input logic [7:0] t0,
                      input logic f, input logic l, input logic u);
    in_data = {t2, t1, t0}; in_vld = 1; in_first = f; in_last = l; in_update = u;
    tick();
    idle();
  endtask

  task automatic expect_lit(input int e0, input int e1, input int e2, input string nm);
    int    n;
    int    e [ND];
    trip_t t;
    e = '{e0, e1, e2};
    n = 0;
    while (got.size() == 0 && n < 20) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (got.size() == 0) begin
      checks++; errors++;
      $display("FAIL %s timeout: no psum_vld within 20 cycles", nm);
    end else begin
      t = got.pop_front();
      for (int k = 0; k < ND; k++) begin
        checks++;
        if (t[k] !== 8'(e[k])) begin
          errors++;
          $display("FAIL %s dut%0d got %h want %h", nm, k, t[k], 8'(e[k]));
        end
      end
    end
  endtask

  initial begin
    rst = 0; in_data = '0; in_weight = '0;
    idle();
    repeat (3) tick();
    chk_en = 1;
    tick();
    rst = 1;
    tick();

    load_w(8'd3); load_w(8'd4); load_w(8'd5); upd();
    beat(8'd6, 8'd1, 8'd2, 1, 1, 0);
    expect_lit(32, 8, 32, "single_beat");

    beat(8'd6, 8'd1, 8'd2, 1, 0, 0);
    beat(8'd6, 8'd1, 8'd2, 0, 1, 0);
    expect_lit(64, 16, 64, "two_beat");

    beat(8'hFF, 8'hFF, 8'hFF, 1, 1, 0);
    expect_lit(8'hF4, 8'hFD, 8'hF4, "neg_floor");

    load_w(8'd127); load_w(8'd127); load_w(8'd127); upd();
    beat(8'd127, 8'd127, 8'd127, 1, 1, 0);
    expect_lit(8'h7F, 8'h7F, 8'h03, "sat_wrap");

    load_w(8'd3); load_w(8'd4); load_w(8'd5); upd();
    load_w(8'd1); load_w(8'd1); load_w(8'd1);
    beat(8'd6, 8'd1, 8'd2, 1, 1, 0);
    beat(8'd6, 8'd1, 8'd2, 1, 1, 1);
    beat(8'd6, 8'd1, 8'd2, 1, 1, 0);
    expect_lit(32, 8, 32, "upd_before");
    expect_lit(32, 8, 32, "upd_same_beat");
    expect_lit(9, 2, 9, "upd_after");

    beat(8'd9, 8'd9, 8'd9, 1, 0, 0);
    beat(8'd9, 8'd9, 8'd9, 0, 0, 0);
    beat(8'd9, 8'd9, 8'd9, 0, 1, 0);
    rst = 0;
    tick();
    rst = 1;
    repeat (6) tick();
    checks++;
    if (got.size() != 0) begin
      errors++;
      $display("FAIL rst_midgroup got %0d strobes want 0", got.size());
      got.delete();
    end
    beat(8'd6, 8'd1, 8'd2, 1, 1, 0);
    expect_lit(0, 0, 0, "post_reset");

    begin
      int glen;
      glen = 0;
      for (int n = 0; n < 400; n++) begin
        in_data    = 24'($urandom);
        in_vld     = ($urandom_range(0, 3) != 0);
        in_first   = ($urandom_range(0, 2) == 0);
        in_last    = (glen >= 6) || ($urandom_range(0, 3) == 0);
        in_weight  = 8'($urandom);
        in_wgt_vld = ($urandom_range(0, 3) == 0);
        in_update  = ($urandom_range(0, 7) == 0);
        if (in_vld) glen = in_last ? 0 : glen + 1;
        tick();
      end
      idle();
      repeat (8) tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
